// File: rtl/dpe_wg_pkg.sv
// Shared types and constants for the WireGuard encryptor peer-table controller.
// peer_t carries one full peer entry; send_cnt sits in the least-significant 64 bits.
package dpe_wg_pkg;

    localparam logic [63:0] REJECT_LIMIT = 64'hFFFF_FFFF_FFFF_DFFF;

    typedef struct packed {
        logic [47:0]  mac;
        logic [31:0]  ip;
        logic [15:0]  port;
        logic [31:0]  remote_id;
        logic [255:0] key;
        logic [63:0]  send_cnt;
    } peer_t;

    // Entry fields written only by the CPU, i.e. everything except send_cnt.
    typedef logic [$bits(peer_t)-65:0] peer_cfg_t;

    typedef enum logic [1:0] {
        PCTL_IDLE = 2'd0,
        PCTL_RD   = 2'd1,
        PCTL_RSP  = 2'd2,
        PCTL_CFG  = 2'd3
    } pctl_state_e;

    function automatic logic peer_drop(input logic valid, input logic [63:0] cnt);
        return ~valid | (cnt >= REJECT_LIMIT);
    endfunction

endpackage

// File: rtl/dpe_wg_peer_ram.sv
// Peer register file: one registered read port, a full-entry write port and a
// monotonic send_cnt write-back port that owns the counter field on a collision.
module dpe_wg_peer_ram
    import dpe_wg_pkg::*;
#(
    parameter int NUM_PEERS = 16,
    parameter int PIDX_W    = $clog2(NUM_PEERS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_i,
    input  logic [PIDX_W-1:0] rd_idx_i,
    output peer_t             rd_peer_o,
    output logic              rd_valid_o,
    input  logic              wr_en_i,
    input  logic [PIDX_W-1:0] wr_idx_i,
    input  peer_t             wr_peer_i,
    input  logic              cnt_req_i,
    input  logic [PIDX_W-1:0] cnt_idx_i,
    input  logic [63:0]       cnt_val_i,
    output logic              cnt_wr_o,
    output logic              cnt_regr_o
);

    peer_cfg_t            cfg_q [NUM_PEERS];
    logic [63:0]          cnt_q [NUM_PEERS];
    logic [NUM_PEERS-1:0] valid_q;
    peer_cfg_t            rd_cfg_q;
    logic [63:0]          rd_cnt_q;
    logic                 rd_valid_q;
    logic                 cnt_gt;

    assign cnt_gt     = cnt_val_i > cnt_q[cnt_idx_i];
    assign cnt_wr_o   = cnt_req_i & valid_q[cnt_idx_i] & cnt_gt;
    assign cnt_regr_o = cnt_req_i & valid_q[cnt_idx_i] & ~cnt_gt;

    // NOTE: the wide CPU-owned fields have no reset; only valid and send_cnt must come up defined.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            cfg_q[wr_idx_i] <= wr_peer_i[$bits(peer_t)-1:64];
        end
        if (rd_en_i) begin
            rd_cfg_q <= cfg_q[rd_idx_i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < NUM_PEERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (wr_en_i) begin
                valid_q[wr_idx_i] <= 1'b1;
                cnt_q[wr_idx_i]   <= wr_peer_i.send_cnt;
            end
            // Placed after the entry write so the write-back wins the send_cnt field.
            if (cnt_wr_o) begin
                cnt_q[cnt_idx_i] <= cnt_val_i;
            end
            if (rd_en_i) begin
                rd_valid_q <= valid_q[rd_idx_i];
                rd_cnt_q   <= (cnt_wr_o && (cnt_idx_i == rd_idx_i)) ? cnt_val_i : cnt_q[rd_idx_i];
            end
        end
    end

    assign rd_peer_o  = {rd_cfg_q, rd_cnt_q};
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/dpe_wg_peer_ctrl.sv
// Peer-table controller: fixed two-cycle lookups with send_cnt forwarding,
// CPU entry writes with starvation protection, and monotonic counter write-backs.
module dpe_wg_peer_ctrl
    import dpe_wg_pkg::*;
#(
    parameter int NUM_PEERS = 16,
    parameter int PIDX_W    = $clog2(NUM_PEERS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_req,
    input  logic [PIDX_W-1:0] enc_req_idx,
    output logic              enc_rdy,
    output logic              enc_rsp_vld,
    output peer_t             enc_rsp_peer,
    output logic              enc_rsp_drop,
    input  logic              enc_upd,
    input  logic [PIDX_W-1:0] enc_upd_idx,
    input  logic [63:0]       enc_upd_cnt,
    input  logic              cfg_wr,
    input  logic [PIDX_W-1:0] cfg_idx,
    input  peer_t             cfg_data,
    output logic              cfg_ack,
    output logic              err_cnt_regr,
    output logic              busy
);

    pctl_state_e       state_q, state_d;
    logic [PIDX_W-1:0] idx_q;
    logic [1:0]        starve_q, starve_d;
    logic              rdy_en_q;
    logic              err_q;
    peer_t             rsp_q, rsp_d, rsp_cur;
    logic              rsp_valid_q, rsp_valid_d;

    logic  accept, starved, cfg_commit, fwd_hit;
    peer_t ram_peer;
    logic  ram_valid, ram_cnt_wr, ram_cnt_regr;

    dpe_wg_peer_ram #(
        .NUM_PEERS (NUM_PEERS),
        .PIDX_W    (PIDX_W)
    ) u_ram (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en_i    (accept),
        .rd_idx_i   (enc_req_idx),
        .rd_peer_o  (ram_peer),
        .rd_valid_o (ram_valid),
        .wr_en_i    (cfg_commit),
        .wr_idx_i   (cfg_idx),
        .wr_peer_i  (cfg_data),
        .cnt_req_i  (enc_upd),
        .cnt_idx_i  (enc_upd_idx),
        .cnt_val_i  (enc_upd_cnt),
        .cnt_wr_o   (ram_cnt_wr),
        .cnt_regr_o (ram_cnt_regr)
    );

    // A CPU write held through three lost arbitration cycles blocks the next lookup.
    assign starved = cfg_wr & (starve_q == 2'd3);
    assign enc_rdy = rdy_en_q & (state_q == PCTL_IDLE) & ~starved;
    assign accept  = enc_req & enc_rdy;
    assign fwd_hit = ram_cnt_wr & (enc_upd_idx == idx_q);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cfg_commit = 1'b0;
        case (state_q)
            PCTL_IDLE: begin
                if (accept)      state_d = PCTL_RD;
                else if (cfg_wr) state_d = PCTL_CFG;
            end
            PCTL_RD:  state_d = PCTL_RSP;
            PCTL_RSP: state_d = PCTL_IDLE;
            PCTL_CFG: begin
                if (!cfg_wr) begin
                    state_d = PCTL_IDLE;
                end else if (!enc_upd) begin
                    cfg_commit = 1'b1;
                    state_d    = PCTL_IDLE;
                end
            end
            default: state_d = PCTL_IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!cfg_wr || cfg_commit) begin
            starve_d = 2'd0;
        end else if ((state_q != PCTL_CFG) && (starve_q != 2'd3)) begin
            starve_d = starve_q + 2'd1;
        end
    end

    // A write-back landing while the response is on the bus is reflected immediately.
    always_comb begin
        rsp_cur = rsp_q;
        if ((state_q == PCTL_RSP) && fwd_hit) begin
            rsp_cur.send_cnt = enc_upd_cnt;
        end
    end

    always_comb begin
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        if (state_q == PCTL_RD) begin
            rsp_d       = ram_peer;
            rsp_valid_d = ram_valid;
            if (fwd_hit) begin
                rsp_d.send_cnt = enc_upd_cnt;
            end
        end else if (state_q == PCTL_RSP) begin
            rsp_d = rsp_cur;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PCTL_IDLE;
            idx_q       <= '0;
            starve_q    <= 2'd0;
            rdy_en_q    <= 1'b0;
            err_q       <= 1'b0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            rdy_en_q    <= 1'b1;
            err_q       <= ram_cnt_regr;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            if (accept) begin
                idx_q <= enc_req_idx;
            end
        end
    end

    assign enc_rsp_vld  = (state_q == PCTL_RSP);
    assign enc_rsp_peer = rsp_cur;
    assign enc_rsp_drop = (state_q == PCTL_RSP) & peer_drop(rsp_valid_q, rsp_cur.send_cnt);
    assign cfg_ack      = cfg_commit;
    assign err_cnt_regr = err_q;
    assign busy         = (state_q != PCTL_IDLE);

endmodule

// File: tb/tb_dpe_wg_peer_ctrl.sv
// Directed bench for dpe_wg_peer_ctrl: a per-cycle vector table for lookups,
// forwarding and regressions, then hand sequences for arbitration, exhaustion and reset.
module tb_dpe_wg_peer_ctrl;
    import dpe_wg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enc_req;
    logic [3:0]  enc_req_idx;
    logic        enc_rdy;
    logic        enc_rsp_vld;
    peer_t       enc_rsp_peer;
    logic        enc_rsp_drop;
    logic        enc_upd;
    logic [3:0]  enc_upd_idx;
    logic [63:0] enc_upd_cnt;
    logic        cfg_wr;
    logic [3:0]  cfg_idx;
    peer_t       cfg_data;
    logic        cfg_ack;
    logic        err_cnt_regr;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    dpe_wg_peer_ctrl #(.NUM_PEERS(16), .PIDX_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enc_req      (enc_req),
        .enc_req_idx  (enc_req_idx),
        .enc_rdy      (enc_rdy),
        .enc_rsp_vld  (enc_rsp_vld),
        .enc_rsp_peer (enc_rsp_peer),
        .enc_rsp_drop (enc_rsp_drop),
        .enc_upd      (enc_upd),
        .enc_upd_idx  (enc_upd_idx),
        .enc_upd_cnt  (enc_upd_cnt),
        .cfg_wr       (cfg_wr),
        .cfg_idx      (cfg_idx),
        .cfg_data     (cfg_data),
        .cfg_ack      (cfg_ack),
        .err_cnt_regr (err_cnt_regr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [3:0]  ridx;
        logic        upd;
        logic [3:0]  uidx;
        logic [63:0] ucnt;
        logic        cfg;
        logic [3:0]  cidx;
        logic [63:0] ccnt;
        logic [4:0]  e;      // {rdy, vld, ack, regr, busy}
        logic        chk;
        logic        drop;
        logic [63:0] cnt;
    } vec_t;

    vec_t vecs [34];

    function automatic vec_t v(input logic req, input logic [3:0] ridx,
                               input logic upd, input logic [3:0] uidx, input logic [63:0] ucnt,
                               input logic cfg, input logic [3:0] cidx, input logic [63:0] ccnt,
                               input logic [4:0] e, input logic chk, input logic drop,
                               input logic [63:0] cnt);
        vec_t r;
        r.req = req; r.ridx = ridx; r.upd = upd; r.uidx = uidx; r.ucnt = ucnt;
        r.cfg = cfg; r.cidx = cidx; r.ccnt = ccnt; r.e = e; r.chk = chk;
        r.drop = drop; r.cnt = cnt;
        return r;
    endfunction

    function automatic peer_t mk_peer(input logic [3:0] idx, input logic [63:0] cnt);
        peer_t p;
        p.mac       = {44'h020_0000_0ABC, idx};
        p.ip        = {28'hC0A8010, idx};
        p.port      = 16'(51820 + idx);
        p.remote_id = {28'h1234567, idx};
        p.key       = {8{28'hBEEF00D, idx}};
        p.send_cnt  = cnt;
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_hdr(input string name, input logic [3:0] idx);
        peer_t e;
        logic  same;
        e    = mk_peer(idx, 64'd0);
        same = (enc_rsp_peer.mac == e.mac) && (enc_rsp_peer.ip == e.ip) &&
               (enc_rsp_peer.port == e.port) && (enc_rsp_peer.remote_id == e.remote_id) &&
               (enc_rsp_peer.key == e.key);
        check(name, 64'(same), 64'd1);
    endtask

    task automatic idle_inputs();
        enc_req = 1'b0; enc_req_idx = '0;
        enc_upd = 1'b0; enc_upd_idx = '0; enc_upd_cnt = '0;
        cfg_wr  = 1'b0; cfg_idx = '0; cfg_data = '0;
    endtask

    task automatic lookup(input string nm, input logic [3:0] idx, input logic e_drop,
                          input logic [63:0] e_cnt);
        @(posedge clk); #1; enc_req = 1'b1; enc_req_idx = idx;
        @(negedge clk); check({nm, ".rdy"}, 64'(enc_rdy), 64'd1);
        @(posedge clk); #1; enc_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check({nm, ".vld"}, 64'(enc_rsp_vld), 64'd1);
        check({nm, ".drop"}, 64'(enc_rsp_drop), 64'(e_drop));
        check({nm, ".cnt"}, enc_rsp_peer.send_cnt, e_cnt);
    endtask

    task automatic cfg_write(input string nm, input logic [3:0] idx, input logic [63:0] cnt);
        @(posedge clk); #1; cfg_wr = 1'b1; cfg_idx = idx; cfg_data = mk_peer(idx, cnt);
        @(posedge clk); #1;
        @(negedge clk); check({nm, ".ack"}, 64'(cfg_ack), 64'd1);
        @(posedge clk); #1; cfg_wr = 1'b0;
    endtask

    task automatic write_back(input string nm, input logic [3:0] idx, input logic [63:0] cnt,
                              input logic e_regr);
        @(posedge clk); #1; enc_upd = 1'b1; enc_upd_idx = idx; enc_upd_cnt = cnt;
        @(posedge clk); #1; enc_upd = 1'b0;
        @(negedge clk); check({nm, ".regr"}, 64'(err_cnt_regr), 64'(e_regr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] lidx;
        logic       found;
        int         ack_at;
        int         k;

        idle_inputs();
        rst_n = 1'b0;
        lidx  = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst.rdy", 64'(enc_rdy), 64'd0);
        check("rst.vld", 64'(enc_rsp_vld), 64'd0);
        check("rst.ack", 64'(cfg_ack), 64'd0);
        check("rst.regr", 64'(err_cnt_regr), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.drop", 64'(enc_rsp_drop), 64'd0);
        check("rst.peer_cnt", enc_rsp_peer.send_cnt, 64'd0);
        rst_n = 1'b1;

        //             req rid upd uid ucnt cfg cid ccnt  {rdy,vld,ack,regr,busy} chk drop cnt
        vecs[0]  = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b10000, 0, 0, 0);
        vecs[1]  = v(0, 0, 0, 0, 0,  1, 3, 1, 5'b10000, 0, 0, 0);
        vecs[2]  = v(0, 0, 0, 0, 0,  1, 3, 1, 5'b00101, 0, 0, 0);
        vecs[3]  = v(1, 3, 0, 0, 0,  0, 0, 0, 5'b10000, 0, 0, 0);
        vecs[4]  = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b00001, 0, 0, 0);
        vecs[5]  = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b01001, 1, 0, 1);
        vecs[6]  = v(1, 5, 0, 0, 0,  0, 0, 0, 5'b10000, 0, 0, 0);
        vecs[7]  = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b00001, 0, 0, 0);
        vecs[8]  = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b01001, 1, 1, 0);
        vecs[9]  = v(1, 3, 0, 0, 0,  0, 0, 0, 5'b10000, 0, 0, 0);
        vecs[10] = v(0, 0, 1, 3, 7,  0, 0, 0, 5'b00001, 0, 0, 0);
        vecs[11] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b01001, 1, 0, 7);
        vecs[12] = v(1, 3, 0, 0, 0,  0, 0, 0, 5'b10000, 0, 0, 0);
        vecs[13] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b00001, 0, 0, 0);
        vecs[14] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b01001, 1, 0, 7);
        vecs[15] = v(0, 0, 1, 3, 5,  0, 0, 0, 5'b10000, 0, 0, 0);
        vecs[16] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b10010, 0, 0, 0);
        vecs[17] = v(1, 3, 0, 0, 0,  0, 0, 0, 5'b10000, 0, 0, 0);
        vecs[18] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b00001, 0, 0, 0);
        vecs[19] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b01001, 1, 0, 7);
        vecs[20] = v(1, 3, 0, 0, 0,  0, 0, 0, 5'b10000, 0, 0, 0);
        vecs[21] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b00001, 0, 0, 0);
        vecs[22] = v(0, 0, 1, 3, 9,  0, 0, 0, 5'b01001, 1, 0, 9);
        vecs[23] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b10000, 1, 0, 9);
        vecs[24] = v(1, 3, 0, 0, 0,  0, 0, 0, 5'b10000, 1, 0, 9);
        vecs[25] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b00001, 0, 0, 0);
        vecs[26] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b01001, 1, 0, 9);
        vecs[27] = v(0, 0, 1, 5, 3,  0, 0, 0, 5'b10000, 0, 0, 0);
        vecs[28] = v(1, 5, 0, 0, 0,  0, 0, 0, 5'b10000, 0, 0, 0);
        vecs[29] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b00001, 0, 0, 0);
        vecs[30] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b01001, 1, 1, 0);
        vecs[31] = v(1, 3, 1, 3, 10, 0, 0, 0, 5'b10000, 0, 0, 0);
        vecs[32] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b00001, 0, 0, 0);
        vecs[33] = v(0, 0, 0, 0, 0,  0, 0, 0, 5'b01001, 1, 0, 10);

        for (int i = 0; i < 34; i++) begin
            @(posedge clk); #1;
            enc_req = vecs[i].req; enc_req_idx = vecs[i].ridx;
            enc_upd = vecs[i].upd; enc_upd_idx = vecs[i].uidx; enc_upd_cnt = vecs[i].ucnt;
            cfg_wr  = vecs[i].cfg; cfg_idx = vecs[i].cidx;
            cfg_data = mk_peer(vecs[i].cidx, vecs[i].ccnt);
            if (vecs[i].req) lidx = vecs[i].ridx;
            @(negedge clk);
            check($sformatf("vec%0d.rdy", i), 64'(enc_rdy), 64'(vecs[i].e[4]));
            check($sformatf("vec%0d.vld", i), 64'(enc_rsp_vld), 64'(vecs[i].e[3]));
            check($sformatf("vec%0d.ack", i), 64'(cfg_ack), 64'(vecs[i].e[2]));
            check($sformatf("vec%0d.regr", i), 64'(err_cnt_regr), 64'(vecs[i].e[1]));
            check($sformatf("vec%0d.busy", i), 64'(busy), 64'(vecs[i].e[0]));
            if (vecs[i].chk) begin
                check($sformatf("vec%0d.cnt", i), enc_rsp_peer.send_cnt, vecs[i].cnt);
                if (vecs[i].e[3]) begin
                    check($sformatf("vec%0d.drop", i), 64'(enc_rsp_drop), 64'(vecs[i].drop));
                    if (!vecs[i].drop) check_hdr($sformatf("vec%0d.hdr", i), lidx);
                end
            end
        end
        @(posedge clk); #1; idle_inputs();

        // Contention: back-to-back lookups with a held CPU write
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_idx = 4'd7; cfg_data = mk_peer(4'd7, 64'd2);
        enc_req = 1'b1; enc_req_idx = 4'd3;
        found = 1'b0; ack_at = 0; k = 0;
        while (!found && k <= 7) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            if (cfg_ack) begin found = 1'b1; ack_at = k; end
            k++;
        end
        check("contention.ack_seen", 64'(found), 64'd1);
        check("contention.ack_within_7", 64'(ack_at <= 7), 64'd1);
        @(posedge clk); #1; idle_inputs();
        repeat (3) @(posedge clk);
        lookup("contention.peer7", 4'd7, 1'b0, 64'd2);

        // Write-back during the CFG cycle delays the ack by one cycle
        @(posedge clk); #1; cfg_wr = 1'b1; cfg_idx = 4'd8; cfg_data = mk_peer(4'd8, 64'd4);
        @(negedge clk); check("cfgupd.c0_ack", 64'(cfg_ack), 64'd0);
        @(posedge clk); #1; enc_upd = 1'b1; enc_upd_idx = 4'd3; enc_upd_cnt = 64'd11;
        @(negedge clk); check("cfgupd.c1_ack", 64'(cfg_ack), 64'd0);
        check("cfgupd.c1_busy", 64'(busy), 64'd1);
        @(posedge clk); #1; enc_upd = 1'b0;
        @(negedge clk); check("cfgupd.c2_ack", 64'(cfg_ack), 64'd1);
        @(posedge clk); #1; cfg_wr = 1'b0;
        lookup("cfgupd.peer3", 4'd3, 1'b0, 64'd11);
        lookup("cfgupd.peer8", 4'd8, 1'b0, 64'd4);

        // CPU write abandoned before the ack
        @(posedge clk); #1; cfg_wr = 1'b1; cfg_idx = 4'd9; cfg_data = mk_peer(4'd9, 64'd1);
        @(negedge clk); check("abandon.c0_ack", 64'(cfg_ack), 64'd0);
        @(posedge clk); #1; cfg_wr = 1'b0;
        @(negedge clk); check("abandon.c1_ack", 64'(cfg_ack), 64'd0);
        @(posedge clk); #1;
        @(negedge clk); check("abandon.c2_busy", 64'(busy), 64'd0);
        check("abandon.c2_ack", 64'(cfg_ack), 64'd0);
        lookup("abandon.peer9", 4'd9, 1'b1, 64'd0);

        // Counter exhaustion
        cfg_write("exh.cfg4", 4'd4, REJECT_LIMIT - 64'd1);
        lookup("exh.below", 4'd4, 1'b0, REJECT_LIMIT - 64'd1);
        write_back("exh.up_limit", 4'd4, REJECT_LIMIT, 1'b0);
        lookup("exh.at_limit", 4'd4, 1'b1, REJECT_LIMIT);
        write_back("exh.up_max", 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        lookup("exh.max", 4'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        write_back("exh.max_again", 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

        // Reset asserted while a lookup sits in RD
        @(posedge clk); #1; enc_req = 1'b1; enc_req_idx = 4'd3;
        @(posedge clk); #1; enc_req = 1'b0; #1; rst_n = 1'b0;
        @(negedge clk);
        check("rstrd.vld0", 64'(enc_rsp_vld), 64'd0);
        check("rstrd.busy", 64'(busy), 64'd0);
        check("rstrd.rdy", 64'(enc_rdy), 64'd0);
        @(negedge clk);
        check("rstrd.vld1", 64'(enc_rsp_vld), 64'd0);
        rst_n = 1'b1;
        lookup("rstrd.peer3", 4'd3, 1'b1, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
